// File: rtl/ptp_stamp_capture.sv
// Per-source timestamp capture FIFOs drained by host over the register bus.
// Define PTP_STAMP_OVERWRITE_EN to make a full FIFO drop its oldest entry instead of the new stamp.
module ptp_stamp_capture #(
    parameter int STAMP_WIDTH    = 64,
    parameter int NUM_QUEUES     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [STAMP_WIDTH-1:0]    counter_val,
    input  logic [NUM_QUEUES/2-1:0]   valid_rx,
    input  logic [NUM_QUEUES/2-1:0]   valid_tx,
    input  logic                      stamp_reg_req,
    input  logic                      stamp_reg_rd_wr_L,
    input  logic [REG_ADDR_WIDTH-1:0] stamp_reg_addr,
    input  logic [REG_DATA_WIDTH-1:0] stamp_reg_wr_data,
    output logic [REG_DATA_WIDTH-1:0] stamp_reg_rd_data,
    output logic                      stamp_reg_ack,
    output logic [NUM_QUEUES-1:0]     stamp_avail
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int SRC_W = REG_ADDR_WIDTH - 2;
    localparam logic [REG_DATA_WIDTH-1:0] BAD_ADDR_DATA = REG_DATA_WIDTH'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } reg_state_e;

    reg_state_e                 state_r;
    logic [REG_DATA_WIDTH-1:0]  rd_data_r;
    logic                       ack_r;
    logic [NUM_QUEUES-1:0]      avail_r;

    logic [STAMP_WIDTH-1:0]     mem_r   [NUM_QUEUES][FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_r [NUM_QUEUES];
    logic [PTR_W-1:0]           rd_ptr_r [NUM_QUEUES];
    logic [OCC_W-1:0]           occ_r    [NUM_QUEUES];
    logic [REG_DATA_WIDTH-1:0]  drops_r  [NUM_QUEUES];
    logic [REG_DATA_WIDTH-1:0]  hold_r   [NUM_QUEUES];

    logic [NUM_QUEUES-1:0]      strobe_s;
    logic [SRC_W-1:0]           src_s;
    logic [SRC_W-1:0]           src_idx_s;
    logic [1:0]                 reg_sel_s;
    logic                       src_ok_s;
    logic                       acc_s;
    logic [OCC_W-1:0]           occ_sel_s;
    logic [STAMP_WIDTH-1:0]     head_sel_s;
    logic [REG_DATA_WIDTH-1:0]  rd_val_s;
    logic [REG_DATA_WIDTH-1:0]  hold_val_s;
    logic [NUM_QUEUES-1:0]      push_s;
    logic [NUM_QUEUES-1:0]      adv_s;
    logic [NUM_QUEUES-1:0]      pop_s;
    logic [NUM_QUEUES-1:0]      drop_s;
    logic [NUM_QUEUES-1:0]      clr_s;
    logic [NUM_QUEUES-1:0]      hold_we_s;
    logic [OCC_W-1:0]           occ_nxt_s [NUM_QUEUES];
    logic                       unused_wr_data_s;

    assign strobe_s          = {valid_tx, valid_rx};
    assign unused_wr_data_s  = ^stamp_reg_wr_data;
    assign stamp_reg_rd_data = rd_data_r;
    assign stamp_reg_ack     = ack_r;
    assign stamp_avail       = avail_r;

    // Address decode and read-data selection for the addressed source
    always_comb begin
        src_s      = stamp_reg_addr[REG_ADDR_WIDTH-1:2];
        reg_sel_s  = stamp_reg_addr[1:0];
        src_ok_s   = (int'(src_s) < NUM_QUEUES);
        src_idx_s  = src_ok_s ? src_s : '0;
        acc_s      = (state_r == ST_IDLE) && stamp_reg_req;
        occ_sel_s  = occ_r[src_idx_s];
        head_sel_s = mem_r[src_idx_s][rd_ptr_r[src_idx_s]];
        hold_val_s = (occ_sel_s != '0) ? head_sel_s[31:0] : '0;
        rd_val_s   = '0;
        if (!src_ok_s) begin
            rd_val_s = BAD_ADDR_DATA;
        end else begin
            case (reg_sel_s)
                2'd0:    rd_val_s = (occ_sel_s != '0) ? head_sel_s[63:32] : '0;
                2'd1:    rd_val_s = hold_r[src_idx_s];
                2'd2:    rd_val_s = REG_DATA_WIDTH'(occ_sel_s);
                2'd3:    rd_val_s = drops_r[src_idx_s];
                default: rd_val_s = '0;
            endcase
        end
    end

    // Per-source push/pop/drop decisions; a pop in the same edge frees the slot for the push
    always_comb begin
        push_s    = '0;
        adv_s     = '0;
        pop_s     = '0;
        drop_s    = '0;
        clr_s     = '0;
        hold_we_s = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            occ_nxt_s[q] = occ_r[q];
            hold_we_s[q] = acc_s && stamp_reg_rd_wr_L && src_ok_s &&
                           (int'(src_s) == q) && (reg_sel_s == 2'd0);
            pop_s[q]     = hold_we_s[q] && (occ_r[q] != '0);
            clr_s[q]     = acc_s && !stamp_reg_rd_wr_L && src_ok_s &&
                           (int'(src_s) == q) && (reg_sel_s == 2'd3);
            if (strobe_s[q] && (occ_r[q] == OCC_W'(FIFO_DEPTH)) && !pop_s[q]) begin
                drop_s[q] = 1'b1;
`ifdef PTP_STAMP_OVERWRITE_EN
                push_s[q] = 1'b1;
                adv_s[q]  = 1'b1;
`else
                push_s[q] = 1'b0;
                adv_s[q]  = 1'b0;
`endif
            end else begin
                drop_s[q] = 1'b0;
                push_s[q] = strobe_s[q];
                adv_s[q]  = pop_s[q];
            end
            occ_nxt_s[q] = occ_r[q] + OCC_W'(push_s[q]) - OCC_W'(adv_s[q]);
        end
    end

    // Stamp storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (push_s[q]) begin
                mem_r[q][wr_ptr_r[q]] <= counter_val;
            end
        end
    end

    // FIFO pointers, occupancy, drop counters and low-word hold registers
    always_ff @(posedge clk) begin
        if (reset) begin
            avail_r <= '0;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                wr_ptr_r[q] <= '0;
                rd_ptr_r[q] <= '0;
                occ_r[q]    <= '0;
                drops_r[q]  <= '0;
                hold_r[q]   <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                wr_ptr_r[q] <= wr_ptr_r[q] + PTR_W'(push_s[q]);
                rd_ptr_r[q] <= rd_ptr_r[q] + PTR_W'(adv_s[q]);
                occ_r[q]    <= occ_nxt_s[q];
                avail_r[q]  <= (occ_nxt_s[q] != '0);
                // Clear applies first, then a drop in the same cycle still counts
                if (clr_s[q]) begin
                    drops_r[q] <= drop_s[q] ? REG_DATA_WIDTH'(1) : '0;
                end else if (drop_s[q] && (drops_r[q] != '1)) begin
                    drops_r[q] <= drops_r[q] + REG_DATA_WIDTH'(1);
                end
                if (hold_we_s[q]) begin
                    hold_r[q] <= hold_val_s;
                end
            end
        end
    end

    // Register handshake: one ack per request, then wait for request release
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ack_r     <= 1'b0;
            rd_data_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (stamp_reg_req) begin
                        state_r   <= ST_ACK;
                        ack_r     <= 1'b1;
                        rd_data_r <= stamp_reg_rd_wr_L ? rd_val_s : '0;
                    end else begin
                        ack_r <= 1'b0;
                    end
                end
                ST_ACK: begin
                    ack_r   <= 1'b0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    ack_r <= 1'b0;
                    if (!stamp_reg_req) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    ack_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptp_stamp_capture.sv
// Directed self-checking bench for ptp_stamp_capture (default 8 queues, depth 4).
module tb_ptp_stamp_capture;

    logic        clk;
    logic        reset;
    logic [63:0] counter_val;
    logic [3:0]  valid_rx;
    logic [3:0]  valid_tx;
    logic        stamp_reg_req;
    logic        stamp_reg_rd_wr_L;
    logic [4:0]  stamp_reg_addr;
    logic [31:0] stamp_reg_wr_data;
    logic [31:0] stamp_reg_rd_data;
    logic        stamp_reg_ack;
    logic [7:0]  stamp_avail;

    int checks_r = 0;
    int errors_r = 0;

    ptp_stamp_capture dut (
        .clk               (clk),
        .reset             (reset),
        .counter_val       (counter_val),
        .valid_rx          (valid_rx),
        .valid_tx          (valid_tx),
        .stamp_reg_req     (stamp_reg_req),
        .stamp_reg_rd_wr_L (stamp_reg_rd_wr_L),
        .stamp_reg_addr    (stamp_reg_addr),
        .stamp_reg_wr_data (stamp_reg_wr_data),
        .stamp_reg_rd_data (stamp_reg_rd_data),
        .stamp_reg_ack     (stamp_reg_ack),
        .stamp_avail       (stamp_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One register transaction; optional strobes ride along in the request cycle
    task automatic reg_xfer(input logic rd, input logic [4:0] addr, input logic [31:0] wdata,
                            input int hold, input logic [7:0] stb, output logic [31:0] data);
        int lat;
        int acks;
        lat  = -1;
        acks = 0;
        data = 32'h0;
        @(negedge clk);
        stamp_reg_req     = 1'b1;
        stamp_reg_rd_wr_L = rd;
        stamp_reg_addr    = addr;
        stamp_reg_wr_data = wdata;
        valid_rx          = stb[3:0];
        valid_tx          = stb[7:4];
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            valid_rx = 4'h0;
            valid_tx = 4'h0;
            if (stamp_reg_ack) begin
                acks++;
                if (lat < 0) begin
                    lat  = i;
                    data = stamp_reg_rd_data;
                end
            end
            if (lat >= 0 && i >= hold) break;
        end
        stamp_reg_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (stamp_reg_ack) acks++;
        end
        check_val($sformatf("ack_latency a%0d", addr), 64'(lat), 64'd1);
        check_val($sformatf("ack_count a%0d", addr), 64'(acks), 64'd1);
    endtask

    task automatic rd_check(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        reg_xfer(1'b1, addr, 32'h0, 1, 8'h00, d);
        check_val(tag, 64'(d), 64'(exp));
    endtask

    task automatic pulse(input logic [7:0] stb, input logic [63:0] cv);
        @(negedge clk);
        counter_val = cv;
        valid_rx    = stb[3:0];
        valid_tx    = stb[7:4];
        @(negedge clk);
        valid_rx = 4'h0;
        valid_tx = 4'h0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] lo_base;
        reset             = 1'b1;
        counter_val       = 64'h0;
        valid_rx          = 4'h0;
        valid_tx          = 4'h0;
        stamp_reg_req     = 1'b0;
        stamp_reg_rd_wr_L = 1'b1;
        stamp_reg_addr    = 5'd0;
        stamp_reg_wr_data = 32'h0;
        repeat (3) @(negedge clk);
        check_val("rst_avail", 64'(stamp_avail), 64'h0);
        check_val("rst_ack", 64'(stamp_reg_ack), 64'h0);
        check_val("rst_rd_data", 64'(stamp_reg_rd_data), 64'h0);
        reset = 1'b0;

        // single rx capture, split HI/LO read
        pulse(8'h01, 64'h0000_0001_0000_0010);
        check_val("avail0_set", 64'(stamp_avail), 64'h01);
        rd_check(5'd2, 32'd1, "count0_one");
        rd_check(5'd0, 32'h0000_0001, "hi0");
        rd_check(5'd1, 32'h0000_0010, "lo0");
        rd_check(5'd2, 32'd0, "count0_zero");
        check_val("avail0_clr", 64'(stamp_avail), 64'h00);

        // five back-to-back tx[1] strobes into a depth-4 FIFO
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            counter_val = 64'(100 + i);
            valid_tx    = 4'b0010;
        end
        @(negedge clk);
        valid_tx = 4'h0;
        rd_check(5'd22, 32'd4, "count5_full");
        rd_check(5'd23, 32'd1, "drops5");
`ifdef PTP_STAMP_OVERWRITE_EN
        lo_base = 32'd101;
`else
        lo_base = 32'd100;
`endif
        for (int i = 0; i < 4; i++) begin
            rd_check(5'd20, 32'd0, "hi5");
            rd_check(5'd21, lo_base + 32'(i), "lo5");
        end

        // empty FIFO read
        rd_check(5'd8, 32'd0, "hi2_empty");
        rd_check(5'd9, 32'd0, "lo2_empty");
        rd_check(5'd10, 32'd0, "count2_empty");

        // full FIFO: pop and push on the same edge
        for (int i = 0; i < 4; i++) pulse(8'h08, 64'(200 + i));
        rd_check(5'd14, 32'd4, "count3_full");
        counter_val = 64'd204;
        reg_xfer(1'b1, 5'd12, 32'h0, 1, 8'h08, d);
        check_val("hi3_popush", 64'(d), 64'h0);
        rd_check(5'd14, 32'd4, "count3_after");
        rd_check(5'd15, 32'd0, "drops3");
        rd_check(5'd13, 32'd200, "lo3_first");
        for (int i = 0; i < 4; i++) begin
            rd_check(5'd12, 32'd0, "hi3");
            rd_check(5'd13, 32'd201 + 32'(i), "lo3");
        end

        // DROPS clear by write, request held several cycles
        reg_xfer(1'b0, 5'd23, 32'h1234_5678, 5, 8'h00, d);
        rd_check(5'd23, 32'd0, "drops5_clr");

        // all sources capture in the same cycle
        pulse(8'hFF, 64'h0000_0000_0000_ABCD);
        check_val("avail_all", 64'(stamp_avail), 64'hFF);
        for (int s = 0; s < 8; s++) begin
            rd_check(5'(s * 4 + 2), 32'd1, $sformatf("count_all s%0d", s));
            rd_check(5'(s * 4 + 0), 32'd0, $sformatf("hi_all s%0d", s));
            rd_check(5'(s * 4 + 1), 32'h0000_ABCD, $sformatf("lo_all s%0d", s));
        end
        check_val("avail_none", 64'(stamp_avail), 64'h00);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
